// File: rtl/uart_reg_responder.sv
// UART register-access responder: decodes write/read commands, drives the register bus, returns one reply byte.
// Reply request 2 cycles after the last command byte (1 for errors); o_Tx_DV is withheld while the transmitter is active or done.
module uart_reg_responder #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         TIMEOUT_CLKS = 10 * 10 * CLKS_PER_BIT,
    parameter int         ADDR_WIDTH   = 4,
    parameter logic [7:0] OP_WRITE     = 8'h57,
    parameter logic [7:0] OP_READ      = 8'h52,
    parameter logic [7:0] RSP_ACK      = 8'h4B,
    parameter logic [7:0] RSP_ERR      = 8'h45
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done,
    output logic [ADDR_WIDTH-1:0] o_Reg_Addr,
    output logic [7:0]            o_Reg_Wdata,
    output logic                  o_Reg_Wr,
    input  logic [7:0]            i_Reg_Rdata,
    output logic                  o_Busy
);

    localparam int            CNT_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CLKS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_BUS     = 3'd3;
    localparam logic [2:0] S_TX_REQ  = 3'd4;
    localparam logic [2:0] S_TX_WAIT = 3'd5;

    logic [2:0]            state_q,   state_d;
    logic                  is_wr_q,   is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [7:0]            wdata_q,   wdata_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic tx_free;
    logic addr_bad;
    logic timed_out;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_byte_d = tx_byte_q;
        cnt_d     = cnt_q;

        tx_free   = !i_Tx_Active && !i_Tx_Done;
        // Any set bit above the address field makes the address invalid.
        addr_bad  = (i_Rx_Byte >> ADDR_WIDTH) != 8'h00;
        timed_out = (state_q == S_ADDR || state_q == S_DATA) && !i_Rx_DV && (cnt_q == CNT_LAST);

        if (state_q == S_ADDR || state_q == S_DATA) begin
            if (i_Rx_DV || timed_out) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == S_IDLE && i_Rx_DV) begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == OP_WRITE || i_Rx_Byte == OP_READ) begin
                        is_wr_d = (i_Rx_Byte == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        tx_byte_d = RSP_ERR;
                        state_d   = S_TX_REQ;
                    end
                end
            end
            S_ADDR: begin
                if (i_Rx_DV) begin
                    if (addr_bad) begin
                        tx_byte_d = RSP_ERR;
                        state_d   = S_TX_REQ;
                    end else begin
                        addr_d  = i_Rx_Byte[ADDR_WIDTH-1:0];
                        state_d = is_wr_q ? S_DATA : S_BUS;
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (i_Rx_DV) begin
                    wdata_d = i_Rx_Byte;
                    state_d = S_BUS;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                tx_byte_d = is_wr_q ? RSP_ACK : i_Reg_Rdata;
                state_d   = S_TX_REQ;
            end
            S_TX_REQ: begin
                if (tx_free) begin
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (i_Tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            tx_byte_q <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_byte_q <= tx_byte_d;
            cnt_q     <= cnt_d;
        end
    end

    // Request is gated combinationally so it can never coincide with a busy transmitter.
    assign o_Tx_DV     = (state_q == S_TX_REQ) && tx_free;
    assign o_Tx_Byte   = tx_byte_q;
    assign o_Reg_Wr    = (state_q == S_BUS) && is_wr_q;
    assign o_Reg_Addr  = addr_q;
    assign o_Reg_Wdata = wdata_q;
    assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: serial transmitter/receiver models, register bus model, reply and write scoreboards.
module tb_uart_reg_responder;

    localparam int         CPB  = 87;
    localparam int         TO   = 10 * 10 * CPB;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h4B;
    localparam logic [7:0] ERR  = 8'h45;

    logic       clk;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_act;
    logic       hold_act;
    logic       tx_active;
    logic       tx_done;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0]  mem    [16];
    logic [7:0]  shadow [16];
    logic [7:0]  exp_q  [$];
    logic [7:0]  ser_q  [$];
    logic [15:0] wr_exp [$];
    logic [9:0]  tx_bits;
    logic        tx_line;
    logic [7:0]  ser_b;
    logic [7:0]  e_tx;
    logic [7:0]  e_ser;
    logic [15:0] e_wr;

    int n_cmp = 0;
    int n_bad = 0;

    assign tx_active = tx_act | hold_act;
    assign reg_rdata = mem[reg_addr];

    uart_reg_responder dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Reg_Addr  (reg_addr),
        .o_Reg_Wdata (reg_wdata),
        .o_Reg_Wr    (reg_wr),
        .i_Reg_Rdata (reg_rdata),
        .o_Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: serialises each requested byte, then pulses Done for two cycles.
    initial begin
        tx_act  = 1'b0;
        tx_done = 1'b0;
        tx_line = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                check_val("dv_tx_idle", {30'd0, tx_active, tx_done}, 32'd0);
                check_val("tx_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e_tx = exp_q.pop_front();
                    check_val("tx_byte", tx_byte, e_tx);
                    ser_q.push_back(e_tx);
                end
                tx_bits = {1'b1, tx_byte, 1'b0};
                @(posedge clk); #1;
                tx_act = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tx_line = tx_bits[k];
                    repeat (CPB) @(posedge clk);
                    #1;
                end
                tx_act  = 1'b0;
                tx_done = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    // Serial receiver: decodes the line at mid-bit and checks against the reply scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!tx_line) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    ser_b[k] = tx_line;
                end
                repeat (CPB) @(negedge clk);
                check_val("ser_pending", 32'(ser_q.size() != 0), 32'd1);
                if (ser_q.size() != 0) begin
                    e_ser = ser_q.pop_front();
                    check_val("ser_byte", ser_b, e_ser);
                end
            end
        end
    end

    // Register bus model and write scoreboard.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[3] = 8'h5A;
        mem[2] = 8'h77;
        forever begin
            @(negedge clk);
            if (reg_wr) begin
                check_val("wr_pending", 32'(wr_exp.size() != 0), 32'd1);
                if (wr_exp.size() != 0) begin
                    e_wr = wr_exp.pop_front();
                    check_val("wr_addr_data", {20'd0, reg_addr, reg_wdata}, {16'd0, e_wr});
                end
                mem[reg_addr] = reg_wdata;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d, input int gap);
        wr_exp.push_back({a, d});
        exp_q.push_back(ACK);
        shadow[a[3:0]] = d;
        send_byte(OP_W);
        repeat (gap) @(posedge clk);
        send_byte(a);
        repeat (gap) @(posedge clk);
        send_byte(d);
        check_val("wr_strobe_n1", reg_wr, 1'b1);
        check_val("wr_addr_n1", reg_addr, a[3:0]);
        check_val("wr_data_n1", reg_wdata, d);
        @(posedge clk); #1;
        check_val("wr_txdv_n2", tx_dv, 1'b1);
        check_val("wr_txbyte_n2", tx_byte, ACK);
    endtask

    task automatic cmd_read(input logic [7:0] a, input int gap);
        exp_q.push_back(shadow[a[3:0]]);
        send_byte(OP_R);
        repeat (gap) @(posedge clk);
        send_byte(a);
        check_val("rd_no_wr_n1", reg_wr, 1'b0);
        check_val("rd_addr_n1", reg_addr, a[3:0]);
        @(posedge clk); #1;
        check_val("rd_txdv_n2", tx_dv, 1'b1);
        check_val("rd_txbyte_n2", tx_byte, shadow[a[3:0]]);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_txdv"}, tx_dv, 1'b0);
        check_val({tag, "_txbyte"}, tx_byte, 8'h00);
        check_val({tag, "_wr"}, reg_wr, 1'b0);
        check_val({tag, "_addr"}, reg_addr, 4'h0);
        check_val({tag, "_wdata"}, reg_wdata, 8'h00);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        hold_act = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        shadow[3] = 8'h5A;
        shadow[2] = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        @(posedge clk); #1;
        rst = 1'b0;

        cmd_read(8'h03, 870);
        wait_idle("rd3_idle");
        cmd_write(8'h03, 8'hA5, 870);
        wait_idle("wr3_idle");
        cmd_read(8'h03, 0);
        wait_idle("rd3b_idle");

        // Unknown opcode: reply the very next cycle.
        exp_q.push_back(ERR);
        send_byte(8'h11);
        check_val("err_op_txdv", tx_dv, 1'b1);
        check_val("err_op_byte", tx_byte, ERR);
        wait_idle("err_op_idle");

        exp_q.push_back(ERR);
        send_byte(OP_R);
        send_byte(8'h13);
        check_val("err_addr_txdv", tx_dv, 1'b1);
        check_val("err_addr_byte", tx_byte, ERR);
        check_val("err_addr_wr", reg_wr, 1'b0);
        wait_idle("err_addr_idle");

        // Timeout in the data phase.
        send_byte(OP_W);
        repeat (870) @(posedge clk);
        send_byte(8'h02);
        n = 0;
        while (busy && n < TO + 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("timeout_clks", n, TO);
        cmd_read(8'h02, 0);
        wait_idle("post_to_idle");

        // Reply withheld while the transmitter reports active.
        hold_act = 1'b1;
        exp_q.push_back(ERR);
        send_byte(8'h11);
        repeat (30) @(posedge clk);
        #1;
        check_val("hold_no_dv", tx_dv, 1'b0);
        check_val("hold_pending", exp_q.size(), 1);
        check_val("hold_busy", busy, 1'b1);
        hold_act = 1'b0;
        #1;
        check_val("hold_release_dv", tx_dv, 1'b1);
        wait_idle("hold_idle");

        // A byte arriving while the reply is in flight is dropped.
        cmd_write(8'h05, 8'h3C, 0);
        repeat (5) @(posedge clk);
        send_byte(OP_W);
        check_val("drop_busy", busy, 1'b1);
        wait_idle("drop_idle");
        cmd_read(8'h05, 0);
        wait_idle("drop_rd_idle");

        // Reset during the data phase.
        send_byte(OP_W);
        send_byte(8'h06);
        check_val("rst_data_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_data");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("rst_data_after", busy, 1'b0);

        // Reset while waiting for the transmitter; its late Done must be ignored.
        cmd_read(8'h05, 0);
        repeat (10) @(posedge clk);
        #1;
        check_val("rst_txw_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_txw");
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!tx_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("rst_txw_done_seen", tx_done, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_val("rst_txw_busy", busy, 1'b0);
        check_val("rst_txw_txdv", tx_dv, 1'b0);

        cmd_write(8'h01, 8'h99, 0);
        wait_idle("final_wr_idle");
        cmd_read(8'h01, 0);
        wait_idle("final_rd_idle");

        n = 0;
        while ((ser_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("exp_q_drained", exp_q.size(), 0);
        check_val("ser_q_drained", ser_q.size(), 0);
        check_val("wr_q_drained", wr_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
